// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants, state enum and operand type for csa_resolve_180
// Optional feature macro used by this slice: CSA_RESOLVE_ZERO_FLAG_EN
package csa_pkg;

  localparam int CSA_WIDTH  = 180;
  localparam int CSA_CHUNK  = 45;
  localparam int CSA_NCHUNK = CSA_WIDTH / CSA_CHUNK;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } csa_state_t;

  typedef logic [CSA_WIDTH-1:0] csa_operand_t;

endpackage

// File: rtl/csa_chunk_add.sv
// rtl/csa_chunk_add.sv - combinational W-bit adder slice with carry in/out
module csa_chunk_add #(
  parameter int W = 45
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_180.sv
// rtl/csa_resolve_180.sv - chunked carry-propagate resolve of a carry-save pair
// Optional macro CSA_RESOLVE_ZERO_FLAG_EN adds the result_zero output.
module csa_resolve_180
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  output logic             result_zero,
`endif
  output logic             carry_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  csa_state_t       state;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             accept;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  logic             zero_reg;
`endif

  // One adder slice, fed from the low end of the shifting operand registers.
  csa_chunk_add #(.W(CHUNK)) u_chunk_add (
    .a    (c_reg[CHUNK-1:0]),
    .b    (s_reg[CHUNK-1:0]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  assign in_ready = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign result   = result_reg;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  assign result_zero = zero_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      c_reg      <= '0;
      s_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      carry_out  <= 1'b0;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
      zero_reg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        c_reg     <= c_in;
        s_reg     <= s_in;
        carry_reg <= 1'b0;
        cnt       <= '0;
        state     <= RUN;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        zero_reg  <= 1'b1;
`endif
      end
      case (state)
        RUN: begin
          // Chunks enter at the top, so after NCHUNK shifts chunk 0 sits at bit 0.
          result_reg <= {chunk_sum, result_reg[WIDTH-1:CHUNK]};
          carry_reg  <= chunk_cout;
          c_reg      <= c_reg >> CHUNK;
          s_reg      <= s_reg >> CHUNK;
          cnt        <= cnt + 1'b1;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
          zero_reg   <= zero_reg && (chunk_sum == '0) && !chunk_cout;
`endif
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            carry_out <= chunk_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_180.sv
// tb/tb_csa_resolve_180.sv - scoreboard bench for csa_resolve_180
module tb_csa_resolve_180;
  import csa_pkg::*;

  localparam int W = CSA_WIDTH;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  csa_operand_t c_in;
  csa_operand_t s_in;
  logic         out_valid;
  logic         out_ready;
  csa_operand_t result;
  logic         carry_out;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  logic         result_zero;
`endif

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  csa_resolve_180 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .c_in        (c_in),
    .s_in        (s_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    .result_zero (result_zero),
`endif
    .carry_out   (carry_out)
  );

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %h with empty queue", result);
      end else begin
        e = q.pop_front();
        chk("sb_result", {1'b0, result}, {1'b0, e.r});
        chk("sb_carry", {{W{1'b0}}, carry_out}, {{W{1'b0}}, e.co});
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        chk("sb_zero", {{W{1'b0}}, result_zero}, {{W{1'b0}}, e.z});
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input csa_operand_t c, input csa_operand_t s,
                      input csa_operand_t er, input logic eco, input logic push);
    int n = 0;
    c_in = c;
    s_in = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      @(posedge clk);
      if (push) q.push_back('{r: er, co: eco, z: (er == '0) && !eco});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic latency_check(input string name);
    chk({name, "_t0"}, {{W{1'b0}}, out_valid}, '0);
    repeat (3) @(posedge clk);
    #1 chk({name, "_t3"}, {{W{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1 chk({name, "_t4"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(posedge clk);
    end
    #1 chk("drain", {{W{1'b0}}, 1'b0}, {{W{1'b0}}, (q.size() != 0 || out_valid)});
  endtask

  function automatic csa_operand_t rnd();
    csa_operand_t v = '0;
    for (int i = 0; i < 6; i++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  initial begin
    csa_operand_t one;
    csa_operand_t ones;
    csa_operand_t a;
    csa_operand_t b;
    logic [W:0]   sum;
    int           n;
    one  = 1;
    ones = '1;
    rst = 1'b1;
    in_valid = 1'b0;
    c_in = '0;
    s_in = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    chk("rst_result", {1'b0, result}, '0);
    chk("rst_carry", {{W{1'b0}}, carry_out}, '0);

    // Basic add plus latency
    send('0, one, one, 1'b0, 1'b1);
    latency_check("lat_basic");
    wait_drain();

    // Full ripple, chunk-boundary carries
    send(one, ones, '0, 1'b1, 1'b1);
    send(one << 44, one << 44, one << 45, 1'b0, 1'b1);
    send(one << 179, one << 179, '0, 1'b1, 1'b1);
    send('0, '0, '0, 1'b0, 1'b1);
    send(ones, ones, ones - one, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    send(one << 90, (one << 90) - one, (one << 91) - one, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", {1'b0, result}, {1'b0, (one << 91) - one});
      chk("bp_in_ready", {{W{1'b0}}, in_ready}, '0);
      chk("bp_out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(W'(100), W'(23), W'(123), 1'b0, 1'b1);
    latency_check("lat_bp");
    wait_drain();

    // Reset on the second RUN cycle discards the operation
    send(W'(7), W'(9), '0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk("post_rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    end
    send(W'(3), W'(5), W'(8), 1'b0, 1'b1);
    wait_drain();

    // Random operands with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = rnd();
      b = ($urandom_range(0, 7) == 0) ? ~a + W'($urandom_range(0, 1)) : rnd();
      sum = {1'b0, a} + {1'b0, b};
      send(a, b, sum[W-1:0], sum[W], 1'b1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
